// File: rtl/ym3438_mix_pkg.sv
// Shared constants and helpers for the YM3438 DAC output mixer.
// Channel samples arrive offset-binary and are summed as two's complement.
package ym3438_mix_pkg;

  localparam int NUM_CH_DEF = 6;
  localparam int ACC_W_DEF  = 12;
  localparam int OUT_W_DEF  = 16;

  // Offset binary (256 = zero) to signed: flipping the MSB re-centres the range.
  function automatic logic signed [8:0] off_to_signed(input logic [8:0] v);
    return {~v[8], v[7:0]};
  endfunction

endpackage

// File: rtl/ym3438_mix_acc.sv
// One pan-gated signed accumulator lane; loads on the first slot of a frame,
// adds on every other enabled slot.
module ym3438_mix_acc
  import ym3438_mix_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    MCLK,
  input  logic                    IC,
  input  logic                    en,
  input  logic                    load,
  input  logic                    gate,
  input  logic signed [8:0]       sample,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] contrib;

  always_comb begin
    contrib = '0;
    if (gate) contrib = {{(ACC_W-9){sample[8]}}, sample};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      acc <= '0;
    end else if (en) begin
      if (load) acc <= contrib;
      else      acc <= acc + contrib;   // wraps by design; range cannot overflow
    end
  end

endmodule

// File: rtl/ym3438_dac_mixer.sv
// Captures time-multiplexed channel outputs, pans them into stereo sums and
// presents one stereo sample per frame with a single-MCLK valid strobe.
module ym3438_dac_mixer
  import ym3438_mix_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                    MCLK,
  input  logic                    IC,
  input  logic                    c1,
  input  logic [8:0]              ch_out,
  input  logic [1:0]              ch_pan,
  input  logic                    ch_valid,
  input  logic                    frame_sync,
  input  logic                    err_clr,
  output logic signed [OUT_W-1:0] out_l,
  output logic signed [OUT_W-1:0] out_r,
  output logic                    out_valid,
  output logic                    frame_err
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic signed [8:0]       sample;
  logic signed [ACC_W-1:0] acc_l, acc_r;
  logic [CNT_W-1:0]        slot_cnt;
  logic                    primed;
  logic                    emit;
  logic                    err_set;

  assign sample  = off_to_signed(ch_out);
  assign emit    = c1 && frame_sync && primed;
  assign err_set = emit && (slot_cnt != CNT_W'(NUM_CH));

  ym3438_mix_acc #(.ACC_W(ACC_W)) u_acc_l (
    .MCLK   (MCLK),
    .IC     (IC),
    .en     (c1),
    .load   (frame_sync),
    .gate   (ch_valid & ch_pan[1]),
    .sample (sample),
    .acc    (acc_l)
  );

  ym3438_mix_acc #(.ACC_W(ACC_W)) u_acc_r (
    .MCLK   (MCLK),
    .IC     (IC),
    .en     (c1),
    .load   (frame_sync),
    .gate   (ch_valid & ch_pan[0]),
    .sample (sample),
    .acc    (acc_r)
  );

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      slot_cnt  <= '0;
      primed    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (emit) begin
        // Sign-extend then shift left by OUT_W-ACC_W: the sum fills the top bits.
        out_l     <= {acc_l, {(OUT_W-ACC_W){1'b0}}};
        out_r     <= {acc_r, {(OUT_W-ACC_W){1'b0}}};
        out_valid <= 1'b1;
      end
      if (c1) begin
        if (frame_sync) begin
          slot_cnt <= {{(CNT_W-1){1'b0}}, ch_valid};
          primed   <= 1'b1;
        end else if (ch_valid && slot_cnt != CNT_MAX) begin
          slot_cnt <= slot_cnt + 1'b1;
        end
        if (err_set)      frame_err <= 1'b1;
        else if (err_clr) frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ym3438_dac_mixer.sv
// Scoreboard bench for ym3438_dac_mixer: a behavioural frame model pushes
// expected stereo samples; a monitor pops them whenever out_valid fires.
module tb_ym3438_dac_mixer;

  logic        MCLK = 1'b0;
  logic        IC = 1'b1;
  logic        c1 = 1'b0;
  logic [8:0]  ch_out = '0;
  logic [1:0]  ch_pan = '0;
  logic        ch_valid = 1'b0;
  logic        frame_sync = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] out_l, out_r;
  logic        out_valid, frame_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } samp_t;
  samp_t exp_q[$];

  int m_l, m_r, m_cnt;
  bit m_primed, m_err;

  always #5 MCLK = ~MCLK;

  ym3438_dac_mixer dut (
    .MCLK       (MCLK),
    .IC         (IC),
    .c1         (c1),
    .ch_out     (ch_out),
    .ch_pan     (ch_pan),
    .ch_valid   (ch_valid),
    .frame_sync (frame_sync),
    .err_clr    (err_clr),
    .out_l      (out_l),
    .out_r      (out_r),
    .out_valid  (out_valid),
    .frame_err  (frame_err)
  );

  // Monitor: every out_valid must match the oldest expected sample.
  always @(negedge MCLK) begin
    if (out_valid === 1'b1) begin
      samp_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out_valid: got out_valid=1 (l=%h r=%h), expected no sample", out_l, out_r);
      end else begin
        e = exp_q.pop_front();
        if (out_l !== e.l || out_r !== e.r) begin
          miscompares++;
          $display("FAIL sample: got l=%h r=%h, expected l=%h r=%h", out_l, out_r, e.l, e.r);
        end
      end
    end
  end

  task automatic model_reset();
    m_l = 0; m_r = 0; m_cnt = 0; m_primed = 0; m_err = 0;
  endtask

  // One c1 slot followed by one c1=0 MCLK; updates the model and checks frame_err.
  task automatic slot(input logic [8:0] v, input logic [1:0] pan, input logic valid,
                      input logic fs, input logic clr);
    int s;
    bit set;
    @(negedge MCLK);
    ch_out = v; ch_pan = pan; ch_valid = valid; frame_sync = fs; err_clr = clr; c1 = 1'b1;
    s = int'(v) - 256;
    set = 0;
    if (fs) begin
      if (m_primed) begin
        exp_q.push_back('{16'(m_l * 16), 16'(m_r * 16)});
        if (m_cnt != 6) set = 1;
      end
      m_l = (valid && pan[1]) ? s : 0;
      m_r = (valid && pan[0]) ? s : 0;
      m_cnt = valid ? 1 : 0;
      m_primed = 1;
    end else begin
      if (valid && pan[1]) m_l += s;
      if (valid && pan[0]) m_r += s;
      if (valid && m_cnt < 7) m_cnt++;
    end
    if (set) m_err = 1;
    else if (clr) m_err = 0;
    @(negedge MCLK);
    vectors++;
    if (frame_err !== m_err) begin
      miscompares++;
      $display("FAIL frame_err: got %b, expected %b", frame_err, m_err);
    end
    c1 = 1'b0; ch_valid = 1'b0; frame_sync = 1'b0; err_clr = 1'b0;
  endtask

  task automatic frame(input logic [8:0] v, input logic [1:0] pan, input int n,
                       input int mute_idx, input logic clr_on_sync);
    for (int i = 0; i < n; i++)
      slot(v, (i == mute_idx) ? 2'b00 : pan, 1'b1, i == 0, (i == 0) ? clr_on_sync : 1'b0);
  endtask

  task automatic test_reset();
    IC = 1'b1;
    #2 IC = 1'b0;
    #2;
    vectors++;
    if (out_l !== 16'h0 || out_r !== 16'h0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got l=%h r=%h v=%b e=%b, expected all zero",
               out_l, out_r, out_valid, frame_err);
    end
    model_reset();
    repeat (2) @(negedge MCLK);
    IC = 1'b1;
  endtask

  task automatic test_mix();
    frame(9'h100, 2'b11, 6, -1, 1'b0);   // priming frame, zeros
    frame(9'h1FF, 2'b10, 6, -1, 1'b0);   // emits 0/0
    frame(9'h000, 2'b11, 6, -1, 1'b0);   // emits 0x5FA0/0
    frame(9'h000, 2'b11, 6, 2, 1'b0);    // emits 0xA000/0xA000
  endtask

  task automatic test_frame_err();
    frame(9'h100, 2'b11, 5, -1, 1'b0);   // emits 0xB000/0xB000; short frame
    frame(9'h100, 2'b11, 6, -1, 1'b0);   // sync sets frame_err
    slot(9'h100, 2'b11, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, expected 1", frame_err);
    end
    slot(9'h100, 2'b11, 1'b0, 1'b0, 1'b1);   // clear
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %b, expected 0", frame_err);
    end
    frame(9'h1C0, 2'b11, 7, -1, 1'b0);   // overlong frame
    frame(9'h1FF, 2'b01, 6, -1, 1'b1);   // clear and set on same edge: set wins
    vectors++;
    if (frame_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set_wins: got %b, expected 1", frame_err);
    end
  endtask

  task automatic test_c1_gating();
    @(negedge MCLK);
    c1 = 1'b0; ch_valid = 1'b1; frame_sync = 1'b1; ch_out = 9'h1FF; ch_pan = 2'b11;
    repeat (6) begin
      @(negedge MCLK);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL c1_gating: got out_valid=%b, expected 0", out_valid);
      end
    end
    ch_valid = 1'b0; frame_sync = 1'b0;
    frame(9'h140, 2'b11, 6, -1, 1'b0);   // emits 0/0x5FA0, unaffected by held inputs
  endtask

  task automatic test_ic_mid_frame();
    frame(9'h100, 2'b11, 3, -1, 1'b0);   // emits 0x1800/0x1800, then partial frame
    #2 IC = 1'b0;
    #1;
    vectors++;
    if (out_l !== 16'h0 || out_r !== 16'h0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ic_mid_frame: got l=%h r=%h v=%b e=%b, expected all zero",
               out_l, out_r, out_valid, frame_err);
    end
    model_reset();
    @(negedge MCLK);
    IC = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 6; i++)
        slot(9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)), 1'b1, i == 0, 1'b0);
    end
    slot(9'h100, 2'b11, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge MCLK);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_samples: got %0d unmatched, expected 0", exp_q.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mix();
    test_frame_err();
    test_c1_gating();
    test_ic_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ym3438_dac_mixer.md
Name: ym3438_dac_mixer

Overview:
- Receiving end of the per-channel output interface driven by the channel/DAC stage (ch_out, ch_pan).
- Captures one time-multiplexed 9-bit offset-binary channel value per channel slot and routes it to left/right by pan.
- Accumulates the six channels of one frame into signed stereo sums.
- At each frame boundary, presents the finished stereo sample with a one-MCLK valid strobe, for the audio mixer or debug output.

Parameters:
- NUM_CH, 6, channel slots expected per frame; used for the slot-count check.
- ACC_W, 12, signed accumulator width; must hold NUM_CH*±256.
- OUT_W, 16, output sample width; sum sign-extended and left-shifted by OUT_W-ACC_W.

Ports:
- MCLK  in  1  master clock
- IC  in  1  asynchronous active-low reset (initial clear)
- c1  in  1  phase-1 enable; all state updates happen only on MCLK edges with c1=1
- ch_out  in  9  channel value, offset binary (256 = zero)
- ch_pan  in  2  {L,R} enables; 0 = muted slot or DAC-load slot
- ch_valid  in  1  current c1 slot carries a channel value
- frame_sync  in  1  current c1 slot is the first channel slot of a frame
- out_l  out  OUT_W  signed left sample
- out_r  out  OUT_W  signed right sample
- out_valid  out  1  one-MCLK pulse when out_l/out_r update
- frame_err  out  1  sticky: a frame did not contain exactly NUM_CH valid slots
- err_clr  in  1  clears frame_err; sampled on a c1 edge

Behaviour:
- Reset (IC=0, asynchronous):
  - acc_l, acc_r, out_l, out_r = 0; out_valid = 0; frame_err = 0; slot_cnt = 0; primed = 0.
- Conversion, combinational: s = {~ch_out[8], ch_out[7:0]} as signed 9-bit. Range -256..+255; 256 maps to 0.
- Per-slot contribution:
  - cl = (ch_valid & ch_pan[1]) ? sext(s) : 0
  - cr = (ch_valid & ch_pan[0]) ? sext(s) : 0
- On a c1 edge with frame_sync=0:
  - acc_l += cl; acc_r += cr.
  - If ch_valid, slot_cnt += 1, saturating at 7.
- On a c1 edge with frame_sync=1, all in the same edge:
  - If primed: out_l/out_r <= acc_l/acc_r of the previous frame, extended to OUT_W; out_valid=1 for this MCLK only.
  - If primed and slot_cnt != NUM_CH: frame_err <= 1.
  - acc_l <= cl, acc_r <= cr. The current slot starts the new frame.
  - slot_cnt <= ch_valid; primed <= 1.
- Latency: a sample appears on the MCLK edge of the first slot of the following frame.
- out_valid is 0 on all other edges, including edges with c1=0.
- Overflow: not possible with NUM_CH=6 and ACC_W=12 (max |sum| 1536). The accumulator wraps, with no saturation logic. An extra slot_cnt beyond NUM_CH is reported via frame_err only.
- err_clr=1 together with a new error on the same edge: the set wins.
- First frame_sync after reset only primes the block: no out_valid, no frame_err check.
- ch_valid=1 with ch_pan=00: counted in slot_cnt, contributes 0 to both sums.
- Inputs are ignored while c1=0. IC asserted mid-frame discards the partial frame.

Decomposition:
- Shared package ym3438_mix_pkg holds:
  - the ACC_W/OUT_W defaults;
  - the offset-to-signed conversion function;
  - the NUM_CH constant.
- One natural sub-module, ym3438_mix_acc: one pan-gated signed accumulator channel with load/add control, instantiated for L and R.
- Slot counter, primed flag, error logic and output registers stay in the top module.

Test Plan:
- Reset then frame_sync; 6 slots ch_out=0x100, pan=11; then frame_sync -> out_valid pulse once; out_l=out_r=0; frame_err=0.
- After priming, 6 slots ch_out=0x1FF, pan=10; then frame_sync -> out_l=6*255=1530 (16-bit: 0x5FA0 after <<4); out_r=0.
- After priming, 6 slots ch_out=0x000, pan=11 -> out_l=out_r=-1536 (0xA000 after <<4). Same frame with pan=00 on slot 3 -> -1280 (0xB000).
- Frame with 5 valid slots, then frame_sync -> frame_err=1 and stays 1. err_clr on a c1 edge clears it. 7 slots sets it again.
- c1=0 for several MCLKs while ch_valid/frame_sync are held high -> no accumulation and no out_valid. First frame_sync after reset produces no out_valid.
- IC pulsed low mid-frame -> all outputs 0 immediately. Next frame_sync only primes; the following frame_sync outputs the correct sum.
